reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 146 ++++++++++++++
 tb/tb_reorder_buffer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order commit reorder buffer with branch-mispredict flush
module reorder_buffer #(
    parameter int ROB_DEPTH = 16,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             alloc_valid,
    input  logic             alloc_has_rd,
    input  logic [4:0]       alloc_rd_index,
    input  logic             alloc_is_branch,
    input  logic             alloc_pred_taken,
    output logic             rob_full,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic [31:0]      wb_value,
    input  logic             wb_taken,
    input  logic [31:0]      wb_target,
    output logic             rob_enable,
    output logic [4:0]       rob_commit_index,
    output logic [TAG_W-1:0] rob_commit_rename,
    output logic [31:0]      rob_commit_value,
    output logic             jump_wrong,
    output logic [31:0]      jump_pc
);

    localparam logic [0:0]       ST_NORMAL  = 1'b0;
    localparam logic [0:0]       ST_FLUSH   = 1'b1;
    localparam logic [TAG_W:0]   FULL_COUNT = (TAG_W+1)'(ROB_DEPTH);
    localparam logic [TAG_W:0]   ONE_CNT    = (TAG_W+1)'(1);
    localparam logic [TAG_W-1:0] ONE_TAG    = TAG_W'(1);

    logic [0:0]           state;
    logic [TAG_W-1:0]     head;
    logic [TAG_W-1:0]     tail;
    logic [TAG_W:0]       count;
    logic [31:0]          flush_target;

    logic [ROB_DEPTH-1:0] busy;
    logic [ROB_DEPTH-1:0] ready;
    logic [ROB_DEPTH-1:0] has_rd_q;
    logic [ROB_DEPTH-1:0] is_branch_q;
    logic [ROB_DEPTH-1:0] pred_q;
    logic [ROB_DEPTH-1:0] taken_q;
    logic [4:0]           rd_q     [ROB_DEPTH];
    logic [31:0]          value_q  [ROB_DEPTH];
    logic [31:0]          target_q [ROB_DEPTH];

    logic do_alloc;
    logic do_commit;
    logic do_wb;
    logic mispredict;
    logic flush_now;

    // Handshake decode: full/flush back-pressure, commit eligibility and flush trigger
    always_comb begin
        rob_full   = (count == FULL_COUNT) || (state != ST_NORMAL);
        alloc_tag  = tail;
        do_alloc   = alloc_valid && !rob_full && rdy;
        do_commit  = rdy && (state == ST_NORMAL) && (count != '0) && busy[head] && ready[head];
        do_wb      = rdy && wb_valid && busy[wb_tag];
        mispredict = is_branch_q[head] && (taken_q[head] != pred_q[head]);
        // A mispredict with a destination register first retires its result, then flushes from FLUSH
        flush_now  = rdy && ((do_commit && mispredict && !has_rd_q[head]) || (state == ST_FLUSH));
    end

    // Entry payload storage; only meaningful while busy, so it carries no reset
    always_ff @(posedge clk) begin
        if (do_alloc && !flush_now) begin
            has_rd_q[tail]    <= alloc_has_rd;
            rd_q[tail]        <= alloc_rd_index;
            is_branch_q[tail] <= alloc_is_branch;
            pred_q[tail]      <= alloc_pred_taken;
        end
        if (do_wb && !flush_now) begin
            value_q[wb_tag]  <= wb_value;
            taken_q[wb_tag]  <= wb_taken;
            target_q[wb_tag] <= wb_target;
        end
    end

    // Pointers, occupancy, entry status, FSM and registered commit/redirect outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= ST_NORMAL;
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            busy              <= '0;
            ready             <= '0;
            flush_target      <= '0;
            rob_enable        <= 1'b0;
            rob_commit_index  <= '0;
            rob_commit_rename <= '0;
            rob_commit_value  <= '0;
            jump_wrong        <= 1'b0;
            jump_pc           <= '0;
        end else begin
            rob_enable <= 1'b0;
            jump_wrong <= 1'b0;
            if (rdy) begin
                if (flush_now) begin
                    busy       <= '0;
                    ready      <= '0;
                    head       <= '0;
                    tail       <= '0;
                    count      <= '0;
                    state      <= ST_NORMAL;
                    jump_wrong <= 1'b1;
                    jump_pc    <= (state == ST_FLUSH) ? flush_target : target_q[head];
                end else begin
                    if (do_wb) begin
                        ready[wb_tag] <= 1'b1;
                    end
                    if (do_alloc) begin
                        busy[tail]  <= 1'b1;
                        ready[tail] <= 1'b0;
                        tail        <= tail + ONE_TAG;
                    end
                    if (do_commit) begin
                        busy[head] <= 1'b0;
                        head       <= head + ONE_TAG;
                        if (has_rd_q[head]) begin
                            rob_enable        <= 1'b1;
                            rob_commit_index  <= rd_q[head];
                            rob_commit_rename <= head;
                            rob_commit_value  <= value_q[head];
                        end
                        if (mispredict) begin
                            state        <= ST_FLUSH;
                            flush_target <= target_q[head];
                        end
                    end
                    if (do_alloc && !do_commit) begin
                        count <= count + ONE_CNT;
                    end else if (!do_alloc && do_commit) begin
                        count <= count - ONE_CNT;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed self-checking bench for reorder_buffer
module tb_reorder_buffer;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        alloc_valid;
    logic        alloc_has_rd;
    logic [4:0]  alloc_rd_index;
    logic        alloc_is_branch;
    logic        alloc_pred_taken;
    logic        rob_full;
    logic [3:0]  alloc_tag;
    logic        wb_valid;
    logic [3:0]  wb_tag;
    logic [31:0] wb_value;
    logic        wb_taken;
    logic [31:0] wb_target;
    logic        rob_enable;
    logic [4:0]  rob_commit_index;
    logic [3:0]  rob_commit_rename;
    logic [31:0] rob_commit_value;
    logic        jump_wrong;
    logic [31:0] jump_pc;

    int n_checks;
    int n_fail;

    reorder_buffer #(.ROB_DEPTH(16), .TAG_W(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .alloc_valid       (alloc_valid),
        .alloc_has_rd      (alloc_has_rd),
        .alloc_rd_index    (alloc_rd_index),
        .alloc_is_branch   (alloc_is_branch),
        .alloc_pred_taken  (alloc_pred_taken),
        .rob_full          (rob_full),
        .alloc_tag         (alloc_tag),
        .wb_valid          (wb_valid),
        .wb_tag            (wb_tag),
        .wb_value          (wb_value),
        .wb_taken          (wb_taken),
        .wb_target         (wb_target),
        .rob_enable        (rob_enable),
        .rob_commit_index  (rob_commit_index),
        .rob_commit_rename (rob_commit_rename),
        .rob_commit_value  (rob_commit_value),
        .jump_wrong        (jump_wrong),
        .jump_pc           (jump_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        alloc_valid      = 1'b0;
        alloc_has_rd     = 1'b0;
        alloc_rd_index   = 5'd0;
        alloc_is_branch  = 1'b0;
        alloc_pred_taken = 1'b0;
        wb_valid         = 1'b0;
        wb_tag           = 4'd0;
        wb_value         = 32'd0;
        wb_taken         = 1'b0;
        wb_target        = 32'd0;
    endtask

    task automatic alloc(input logic has_rd, input logic [4:0] rd, input logic br, input logic pred);
        alloc_valid      = 1'b1;
        alloc_has_rd     = has_rd;
        alloc_rd_index   = rd;
        alloc_is_branch  = br;
        alloc_pred_taken = pred;
    endtask

    task automatic wb(input logic [3:0] tag, input logic [31:0] val, input logic tkn, input logic [31:0] tgt);
        wb_valid  = 1'b1;
        wb_tag    = tag;
        wb_value  = val;
        wb_taken  = tkn;
        wb_target = tgt;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        rdy      = 1'b1;
        idle();
        repeat (2) tick();

        // Reset state
        check("rst_enable", 32'(rob_enable), 32'd0);
        check("rst_jump", 32'(jump_wrong), 32'd0);
        check("rst_full", 32'(rob_full), 32'd0);
        check("rst_tag", 32'(alloc_tag), 32'd0);
        check("rst_count", 32'(dut.count), 32'd0);
        check("rst_pc", jump_pc, 32'd0);
        rst = 1'b1;
        tick();

        // Fill all 16 entries, then try a 17th
        for (int i = 0; i < 16; i++) begin
            alloc(1'b1, 5'(i), 1'b0, 1'b0);
            tick();
        end
        check("fill_full", 32'(rob_full), 32'd1);
        check("fill_count", 32'(dut.count), 32'd16);
        check("fill_tag_wrap", 32'(alloc_tag), 32'd0);
        tick();
        check("alloc17_count", 32'(dut.count), 32'd16);
        wb(4'd0, 32'h55, 1'b0, 32'd0);
        tick();
        check("full_wb_noenable", 32'(rob_enable), 32'd0);
        wb(4'd1, 32'h66, 1'b0, 32'd0);
        tick();
        // Commit at full: alloc rejected even though commit frees a slot
        check("full_commit_en", 32'(rob_enable), 32'd1);
        check("full_commit_val", rob_commit_value, 32'h55);
        check("full_commit_ren", 32'(rob_commit_rename), 32'd0);
        check("full_commit_count", 32'(dut.count), 32'd15);
        check("full_commit_notfull", 32'(rob_full), 32'd0);
        check("full_commit_tag", 32'(alloc_tag), 32'd0);
        wb_valid = 1'b0;
        tick();
        // Simultaneous alloc and commit
        check("simul_en", 32'(rob_enable), 32'd1);
        check("simul_idx", 32'(rob_commit_index), 32'd1);
        check("simul_val", rob_commit_value, 32'h66);
        check("simul_count", 32'(dut.count), 32'd15);
        check("simul_tag", 32'(alloc_tag), 32'd1);

        // rdy low freezes state
        rdy = 1'b0;
        tick();
        check("rdy0_count", 32'(dut.count), 32'd15);
        check("rdy0_tag", 32'(alloc_tag), 32'd1);
        check("rdy0_enable", 32'(rob_enable), 32'd0);
        rdy = 1'b1;
        idle();

        // Asynchronous reset clears immediately
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_count", 32'(dut.count), 32'd0);
        check("async_rst_val", rob_commit_value, 32'd0);
        tick();
        rst = 1'b1;

        // Basic alloc -> wb -> commit
        alloc(1'b1, 5'd5, 1'b0, 1'b0);
        tick();
        check("basic_count", 32'(dut.count), 32'd1);
        idle();
        wb(4'd0, 32'h1234, 1'b0, 32'd0);
        tick();
        check("basic_wb_noenable", 32'(rob_enable), 32'd0);
        idle();
        tick();
        check("basic_en", 32'(rob_enable), 32'd1);
        check("basic_idx", 32'(rob_commit_index), 32'd5);
        check("basic_ren", 32'(rob_commit_rename), 32'd0);
        check("basic_val", rob_commit_value, 32'h1234);
        tick();
        check("basic_pulse", 32'(rob_enable), 32'd0);
        check("basic_count0", 32'(dut.count), 32'd0);

        // Out-of-order writeback, in-order commit (tags 1, 2)
        alloc(1'b1, 5'd7, 1'b0, 1'b0);
        tick();
        alloc(1'b1, 5'd8, 1'b0, 1'b0);
        tick();
        idle();
        wb(4'd2, 32'hB, 1'b0, 32'd0);
        tick();
        idle();
        tick();
        check("ooo_wait_en", 32'(rob_enable), 32'd0);
        check("ooo_wait_count", 32'(dut.count), 32'd2);
        wb(4'd1, 32'hA, 1'b0, 32'd0);
        tick();
        check("ooo_a_ready_en", 32'(rob_enable), 32'd0);
        idle();
        tick();
        check("ooo_a_en", 32'(rob_enable), 32'd1);
        check("ooo_a_idx", 32'(rob_commit_index), 32'd7);
        check("ooo_a_val", rob_commit_value, 32'hA);
        tick();
        check("ooo_b_en", 32'(rob_enable), 32'd1);
        check("ooo_b_ren", 32'(rob_commit_rename), 32'd2);
        check("ooo_b_val", rob_commit_value, 32'hB);
        tick();
        check("ooo_done_en", 32'(rob_enable), 32'd0);
        check("ooo_done_count", 32'(dut.count), 32'd0);

        // Mispredicted branch without rd at tag 3, three younger entries
        alloc(1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            alloc(1'b1, 5'(10 + i), 1'b0, 1'b0);
            tick();
        end
        idle();
        check("br_count4", 32'(dut.count), 32'd4);
        wb(4'd3, 32'd0, 1'b1, 32'h100);
        tick();
        check("br_wb_jump", 32'(jump_wrong), 32'd0);
        idle();
        alloc(1'b1, 5'd3, 1'b0, 1'b0);
        tick();
        check("br_jump", 32'(jump_wrong), 32'd1);
        check("br_pc", jump_pc, 32'h100);
        check("br_noenable", 32'(rob_enable), 32'd0);
        check("br_count0", 32'(dut.count), 32'd0);
        check("br_tag0", 32'(alloc_tag), 32'd0);
        idle();
        tick();
        check("br_pulse", 32'(jump_wrong), 32'd0);

        // Mispredicted JALR with rd=1 at tag 0
        alloc(1'b1, 5'd1, 1'b1, 1'b0);
        tick();
        alloc(1'b1, 5'd9, 1'b0, 1'b0);
        tick();
        idle();
        wb(4'd0, 32'h44, 1'b1, 32'h200);
        tick();
        idle();
        tick();
        check("jalr_en", 32'(rob_enable), 32'd1);
        check("jalr_idx", 32'(rob_commit_index), 32'd1);
        check("jalr_nojump", 32'(jump_wrong), 32'd0);
        check("jalr_full_flush", 32'(rob_full), 32'd1);
        alloc(1'b1, 5'd4, 1'b0, 1'b0);
        tick();
        check("jalr_jump", 32'(jump_wrong), 32'd1);
        check("jalr_pc", jump_pc, 32'h200);
        check("jalr_en_off", 32'(rob_enable), 32'd0);
        check("jalr_count0", 32'(dut.count), 32'd0);
        check("jalr_tag0", 32'(alloc_tag), 32'd0);
        idle();
        tick();
        check("jalr_pulse", 32'(jump_wrong), 32'd0);

        // Reset while in FLUSH
        alloc(1'b1, 5'd2, 1'b1, 1'b0);
        tick();
        idle();
        wb(4'd0, 32'h77, 1'b1, 32'h300);
        tick();
        idle();
        tick();
        check("rstfl_en", 32'(rob_enable), 32'd1);
        rst = 1'b0;
        #1;
        check("rstfl_en0", 32'(rob_enable), 32'd0);
        check("rstfl_pc0", jump_pc, 32'd0);
        check("rstfl_idx0", 32'(rob_commit_index), 32'd0);
        check("rstfl_val0", rob_commit_value, 32'd0);
        check("rstfl_count0", 32'(dut.count), 32'd0);
        check("rstfl_full0", 32'(rob_full), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("rstfl_nojump1", 32'(jump_wrong), 32'd0);
        tick();
        check("rstfl_nojump2", 32'(jump_wrong), 32'd0);

        // Writeback to a non-busy entry is ignored
        wb(4'd0, 32'h99, 1'b0, 32'd0);
        tick();
        idle();
        alloc(1'b1, 5'd6, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        check("stale_wb_en1", 32'(rob_enable), 32'd0);
        tick();
        check("stale_wb_en2", 32'(rob_enable), 32'd0);
        check("stale_wb_count", 32'(dut.count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
